// File: rtl/adc_sample_ctrl_if.sv
// Signal bundle between the serial ADC front-end and its surroundings:
// ADC SPI-style pins plus the conditioned sample stream.
`timescale 1ns/1ps
interface adc_sample_ctrl_if;
  logic        enable;
  logic        adc_sdo;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] sample_data;
  logic        data_valid;
  logic        frame_err;
  logic        busy;

  modport master (
    input  enable, adc_sdo,
    output adc_cs_n, adc_sclk, sample_data, data_valid, frame_err, busy
  );

  modport slave (
    output enable, adc_sdo,
    input  adc_cs_n, adc_sclk, sample_data, data_valid, frame_err, busy
  );
endinterface

// File: rtl/adc_sample_ctrl.sv
// Periodic 16-clock serial ADC reader with leading-zero frame check and
// power-of-two averaging of good frames into a 12-bit DC-link sample stream.
`timescale 1ns/1ps
module adc_sample_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter int CS_SETUP      = 2,
  parameter int SAMPLE_PERIOD = 2000,
  parameter int AVG_LOG2      = 2
) (
  input  logic               clk,
  input  logic               rst,
  adc_sample_ctrl_if.master  bus
);
  localparam int DATA_W  = 12;
  localparam int ACC_W   = DATA_W + AVG_LOG2;
  localparam int GCNT_W  = AVG_LOG2 + 1;
  localparam int PER_W   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TMR_MAX = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [TMR_W-1:0]  SETUP_LAST = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0]  DIV_LAST   = TMR_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0]  PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST  = GCNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, QUIET} state_t;

  state_t              state, state_nxt;
  logic [PER_W-1:0]    pcnt;
  logic [TMR_W-1:0]    tmr;
  logic                phase;
  logic [3:0]          bitcnt;
  logic [15:0]         shreg;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_sum;
  logic [GCNT_W-1:0]   gcnt;
  logic [DATA_W-1:0]   sample_data;
  logic                data_valid;
  logic                frame_err;
  logic                cs_n;
  logic                sclk;
  logic                busy;
  logic                start;
  logic                div_end;

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:AVG_LOG2];
  endfunction

  assign start   = bus.enable && (pcnt == '0) && (state == IDLE);
  assign div_end = (tmr == DIV_LAST);
  assign acc_sum = acc + ACC_W'(shreg[DATA_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // SCLK is low in the first half of each bit period, so it is simply the phase flag
  always_comb begin
    state_nxt = state;
    cs_n      = 1'b1;
    sclk      = 1'b1;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = SETUP;
      end
      SETUP: begin
        cs_n = 1'b0;
        if (tmr == SETUP_LAST) state_nxt = SHIFT;
      end
      SHIFT: begin
        cs_n = 1'b0;
        sclk = phase;
        if (div_end && phase && (bitcnt == 4'hF)) state_nxt = DONE;
      end
      DONE:    state_nxt = QUIET;
      QUIET:   if (div_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt        <= '0;
      tmr         <= '0;
      phase       <= 1'b0;
      bitcnt      <= '0;
      shreg       <= '0;
      acc         <= '0;
      gcnt        <= '0;
      sample_data <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (!bus.enable || (pcnt == PER_LAST)) pcnt <= '0;
      else                                   pcnt <= pcnt + 1'b1;

      // one timer serves setup, half-period and quiet timing; it restarts on every state change
      if ((state_nxt != state) || ((state == SHIFT) && div_end)) tmr <= '0;
      else if (state != IDLE)                                   tmr <= tmr + 1'b1;

      if ((state == SHIFT) && div_end) begin
        phase <= ~phase;
        if (!phase) shreg  <= {shreg[14:0], bus.adc_sdo};
        else        bitcnt <= bitcnt + 1'b1;
      end

      if (state == DONE) begin
        if (shreg[15:12] != 4'h0) begin
          frame_err <= 1'b1;
        end else if (gcnt == GCNT_LAST) begin
          sample_data <= avg_trunc(acc_sum);
          data_valid  <= 1'b1;
          acc         <= '0;
          gcnt        <= '0;
        end else begin
          acc  <= acc_sum;
          gcnt <= gcnt + 1'b1;
        end
      end else if ((state == IDLE) && !bus.enable) begin
        acc  <= '0;
        gcnt <= '0;
      end
    end
  end

  assign bus.adc_cs_n    = cs_n;
  assign bus.adc_sclk    = sclk;
  assign bus.busy        = busy;
  assign bus.sample_data = sample_data;
  assign bus.data_valid  = data_valid;
  assign bus.frame_err   = frame_err;
endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Bench for adc_sample_ctrl: an unaveraged instance at the default rate and an
// averaging instance at a shorter period, driven frame by frame by an ADC model.
`timescale 1ns/1ps
module tb_adc_sample_ctrl;
  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int P0       = 2000;
  localparam int P2       = 400;
  localparam int LAT      = CS_SETUP + 32*CLK_DIV + 1;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  adc_sample_ctrl_if if0 ();
  adc_sample_ctrl_if if2 ();

  adc_sample_ctrl #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .SAMPLE_PERIOD(P0), .AVG_LOG2(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  adc_sample_ctrl #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .SAMPLE_PERIOD(P2), .AVG_LOG2(2))
    dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  int          n_cmp;
  int          n_err;
  int          cyc;
  int          sel;
  logic        cs_s, sclk_s, dv_s, fe_s, busy_s;
  logic [11:0] sd_s;
  int          good_q[$];
  int          exp_sd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sel == 0) begin
      cs_s = if0.adc_cs_n; sclk_s = if0.adc_sclk; dv_s = if0.data_valid;
      fe_s = if0.frame_err; busy_s = if0.busy;    sd_s = if0.sample_data;
    end else begin
      cs_s = if2.adc_cs_n; sclk_s = if2.adc_sclk; dv_s = if2.data_valid;
      fe_s = if2.frame_err; busy_s = if2.busy;    sd_s = if2.sample_data;
    end
  endtask

  task automatic set_sdo(input logic v);
    if0.adc_sdo = v;
    if2.adc_sdo = v;
  endtask

  task automatic set_en(input logic v);
    if (sel == 0) if0.enable = v;
    else          if2.enable = v;
  endtask

  // Reference: discard frames with nonzero leading bits, average every N good codes
  function automatic void model_frame(input logic [15:0] w, output logic dv, output logic fe);
    int navg, sum;
    navg = (sel == 0) ? 1 : 4;
    dv = 1'b0;
    fe = 1'b0;
    if (w[15:12] != 4'h0) begin
      fe = 1'b1;
    end else begin
      good_q.push_back(int'(w[11:0]));
      if (good_q.size() == navg) begin
        sum = 0;
        foreach (good_q[i]) sum += good_q[i];
        exp_sd = sum / navg;
        dv = 1'b1;
        good_q.delete();
      end
    end
  endfunction

  task automatic do_frame(input logic [15:0] word, input int drop_at, input int rst_at,
                          output int c_out);
    int   waited, c, k, low_cnt, stray;
    logic prev_sclk, edv, efe, abort;
    waited = 0;
    c_out  = -1;
    while (cs_s !== 1'b0 && waited < 3*P0) begin
      tick();
      waited++;
    end
    check("frame_start_seen", {31'd0, cs_s === 1'b0}, 32'd1);
    if (cs_s !== 1'b0) return;
    c = cyc; c_out = c; k = 0; low_cnt = 1; stray = 0; abort = 1'b0;
    prev_sclk = sclk_s;
    check("busy_in_frame", {31'd0, busy_s}, 32'd1);
    while (cyc < c + LAT - 1) begin
      tick();
      if (prev_sclk === 1'b1 && sclk_s === 1'b0) begin
        if (k < 16) set_sdo(word[15-k]);
        k++;
        if (k == drop_at) set_en(1'b0);
        if (k == rst_at) begin
          abort = 1'b1;
          break;
        end
      end
      prev_sclk = sclk_s;
      if (cs_s === 1'b0) low_cnt++;
      if (dv_s !== 1'b0 || fe_s !== 1'b0) stray++;
    end
    if (abort) begin
      rst = 1'b1;
      tick();
      check("rst_cs_n", {31'd0, cs_s}, 32'd1);
      check("rst_sclk", {31'd0, sclk_s}, 32'd1);
      check("rst_busy", {31'd0, busy_s}, 32'd0);
      check("rst_sample_data", {20'd0, sd_s}, 32'd0);
      rst = 1'b0;
      good_q.delete();
      exp_sd = 0;
      tick();
      check("restart_after_rst", {31'd0, cs_s}, 32'd0);
      return;
    end
    check("cs_low_cycles", low_cnt, 130);
    check("sclk_falls", k, 16);
    check("stray_strobe", stray, 0);
    model_frame(word, edv, efe);
    tick();
    check("data_valid", {31'd0, dv_s}, {31'd0, edv});
    check("frame_err", {31'd0, fe_s}, {31'd0, efe});
    check("sample_data", {20'd0, sd_s}, exp_sd);
    tick();
    check("strobe_width", {30'd0, dv_s, fe_s}, 32'd0);
    check("sample_hold", {20'd0, sd_s}, exp_sd);
    tick(); tick();
    check("busy_quiet", {31'd0, busy_s}, 32'd1);
    tick();
    check("busy_idle", {30'd0, busy_s, cs_s}, 32'd1);
    if (drop_at > 0) good_q.delete();
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w[11:0]  = 12'($urandom_range(0, 4095));
    w[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          c1, c2, cx, lows;
    logic [15:0] t2 [4];
    logic [15:0] t3 [5];
    n_cmp = 0; n_err = 0; cyc = 0; sel = 2; exp_sd = 0;
    rst = 1'b1;
    if0.enable = 1'b0; if2.enable = 1'b0;
    set_sdo(1'b0);
    tick(); tick(); tick();
    check("reset_cs_n", {31'd0, cs_s}, 32'd1);
    check("reset_sclk", {31'd0, sclk_s}, 32'd1);
    check("reset_sample_data", {20'd0, sd_s}, 32'd0);
    check("reset_strobes", {30'd0, dv_s, fe_s}, 32'd0);
    check("reset_busy", {31'd0, busy_s}, 32'd0);
    rst = 1'b0;
    tick(); tick();
    check("idle_without_enable", {31'd0, cs_s}, 32'd1);

    // Unaveraged instance: single-frame output and exact sample period
    sel = 0; good_q.delete(); exp_sd = 0;
    if0.enable = 1'b1;
    tick();
    check("t1_first_start", {31'd0, cs_s}, 32'd0);
    do_frame(16'h0ABC, 0, 0, c1);
    do_frame(16'h0123, 0, 0, c2);
    check("t1_period", c2 - c1, P0);
    if0.enable = 1'b0;

    // Averaging instance
    sel = 2; good_q.delete(); exp_sd = 0;
    if2.enable = 1'b1;
    tick();
    check("t2_first_start", {31'd0, cs_s}, 32'd0);
    t2 = '{16'd100, 16'd101, 16'd102, 16'd104};
    foreach (t2[i]) do_frame(t2[i], 0, 0, cx);
    t3 = '{16'h0032, 16'h4055, 16'h0010, 16'h0020, 16'h0030};
    foreach (t3[i]) do_frame(t3[i], 0, 0, cx);
    for (int i = 0; i < 4; i++) do_frame(16'h0FFF, 0, 0, cx);
    for (int i = 0; i < 4; i++) do_frame(16'h0000, 0, 0, cx);

    // Enable dropped mid-frame leaves a partial average that must not survive
    do_frame(16'h0200, 0, 0, cx);
    do_frame(16'h0300, 9, 0, cx);
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (cs_s !== 1'b1 || busy_s !== 1'b0) lows++;
    end
    check("quiet_after_drop", lows, 0);
    check("hold_after_drop", {20'd0, sd_s}, exp_sd);
    if2.enable = 1'b1;
    tick();
    check("reenable_start", {31'd0, cs_s}, 32'd0);
    for (int i = 1; i <= 4; i++) do_frame(16'(16 * i), 0, 0, cx);

    for (int i = 0; i < 10; i++) do_frame(rand_word(), 0, 0, cx);

    // Reset in the middle of a shift, then a fresh averaging window
    do_frame(rand_word(), 0, 5, cx);
    for (int i = 0; i < 4; i++) do_frame({4'h0, 12'($urandom_range(0, 4095))}, 0, 0, cx);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
